antisat_key_loader: RTL and testbench

//  Upstream key-provisioning stage for the Anti-SAT-locked c432 core.

---
 rtl/antisat_key_loader.sv | 142 ++++++++++++++
 tb/tb_antisat_key_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/antisat_key_loader.sv
// rtl/antisat_key_loader.sv - serial key loader with parity check and retry limit for the Anti-SAT c432 core
// Optional feature: define KEY_LOAD_TIMEOUT_EN to enable the idle-bit watchdog.
module antisat_key_loader #(
  parameter int                KEY_W       = 6,
  parameter logic [KEY_W-1:0]  DEFAULT_KEY = 6'b000111,
  parameter int                RETRY_MAX   = 3,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic             key_sdata,
  input  logic             key_svalid,
  output logic             key_sready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             load_err,
  output logic             fault
);

  localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, LOCKED, FAULT} state_t;

  state_t             state_q;
  logic [KEY_W-1:0]   shift_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [3:0]         fail_cnt_q;
  logic [3:0]         fail_cnt_d;
  logic [KEY_W-1:0]   key_q;
  logic               key_valid_q;
  logic               sready_q;
  logic               load_err_q;
  logic               fault_q;
  logic               accept;
  logic               parity_bad;
  logic               timeout_hit;
  logic               fail_now;

  assign accept     = key_svalid && sready_q;
  assign parity_bad = (state_q == PARITY) && accept && (^{shift_q, key_sdata});
  assign fail_cnt_d = (fail_cnt_q == 4'(RETRY_MAX)) ? fail_cnt_q : fail_cnt_q + 4'd1;
  assign fail_now   = parity_bad || timeout_hit;

`ifdef KEY_LOAD_TIMEOUT_EN
  logic [7:0] wd_q;

  // A starved link counts as a failed load once TIMEOUT_CYC idle cycles pass in a row.
  assign timeout_hit = (state_q == SHIFT || state_q == PARITY) && !key_svalid &&
                       (wd_q == 8'(TIMEOUT_CYC - 1));

  // Watchdog: counts consecutive idle cycles while bits are expected, cleared by any accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= 8'd0;
    end else if ((state_q == SHIFT || state_q == PARITY) && !fail_now) begin
      if (accept) wd_q <= 8'd0;
      else        wd_q <= wd_q + 8'd1;
    end else begin
      wd_q <= 8'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Load FSM with all outputs registered; a failure from either source takes priority over the state action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      fail_cnt_q  <= 4'd0;
      key_q       <= DEFAULT_KEY;
      key_valid_q <= 1'b0;
      sready_q    <= 1'b0;
      load_err_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      if (fail_now) begin
        load_err_q <= 1'b1;
        fail_cnt_q <= fail_cnt_d;
        shift_q    <= '0;
        bit_cnt_q  <= '0;
        sready_q   <= 1'b0;
        if (fail_cnt_d == 4'(RETRY_MAX)) begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (load_req) begin
              state_q   <= SHIFT;
              bit_cnt_q <= '0;
              sready_q  <= 1'b1;
            end
          end
          SHIFT: begin
            if (accept) begin
              shift_q[bit_cnt_q] <= key_sdata;
              if (bit_cnt_q == CNT_W'(KEY_W - 1)) state_q <= PARITY;
              else                                 bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          PARITY: begin
            if (accept) begin
              state_q  <= LOCKED;
              sready_q <= 1'b0;
            end
          end
          LOCKED: begin
            // Key is published one edge after the parity bit, then frozen.
            if (!key_valid_q) begin
              key_q       <= shift_q;
              key_valid_q <= 1'b1;
            end
          end
          FAULT: begin
            fault_q     <= 1'b1;
            key_q       <= DEFAULT_KEY;
            key_valid_q <= 1'b0;
            sready_q    <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_sready = sready_q;
  assign busy       = sready_q;
  assign key_out    = key_q;
  assign key_valid  = key_valid_q;
  assign load_err   = load_err_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_antisat_key_loader.sv
// tb/tb_antisat_key_loader.sv - directed self-checking bench for antisat_key_loader
module tb_antisat_key_loader;

`ifdef KEY_LOAD_TIMEOUT_EN
  localparam int TCYC = 16;
`else
  localparam int TCYC = 255;
`endif

  localparam logic [5:0] DEF  = 6'b000111;
  localparam logic [5:0] GOOD = 6'b001101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req;
  logic       key_sdata;
  logic       key_svalid;
  logic       key_sready;
  logic [5:0] key_out;
  logic       key_valid;
  logic       busy;
  logic       load_err;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  antisat_key_loader #(.KEY_W(6), .DEFAULT_KEY(6'b000111), .RETRY_MAX(3), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .key_sdata(key_sdata),
    .key_svalid(key_svalid), .key_sready(key_sready), .key_out(key_out),
    .key_valid(key_valid), .busy(busy), .load_err(load_err), .fault(fault)
  );

  always #5 clk = ~clk;

  // Count load_err pulses, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (load_err === 1'b1) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // load_req, six key bits LSB first with optional stalls, then parity bit.
  task automatic load_key(input logic [5:0] k, input logic p, input int stall, input logic poke);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stall; s++) begin
          key_svalid = 1'b0;
          tick();
        end
      end
      key_svalid = 1'b1;
      key_sdata  = k[i];
      if (poke && i == 2) load_req = 1'b1;
      tick();
      load_req = 1'b0;
    end
    key_svalid = 1'b1;
    key_sdata  = p;
    tick();
    key_svalid = 1'b0;
  endtask

  initial begin
    int n;
    int e0;
    logic hit;
    rst_n = 1'b0; load_req = 1'b0; key_sdata = 1'b0; key_svalid = 1'b0;
    tick();
    check("rst_key_out", 32'(key_out), 32'(DEF));
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_sready", 32'(key_sready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_load_err", 32'(load_err), 0);
    check("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    tick();

    // Good load and latency
    load_key(GOOD, 1'b1, 0, 1'b0);
    check("t1_valid_at8", 32'(key_valid), 0);
    check("t1_key_at8", 32'(key_out), 32'(DEF));
    tick();
    check("t1_valid_at9", 32'(key_valid), 1);
    check("t1_key", 32'(key_out), 32'(GOOD));
    check("t1_no_err", 32'(err_seen), 0);
    // Locked: new bits and load_req ignored
    load_key(6'b110010, 1'b1, 0, 1'b0);
    tick();
    check("t4_locked_key", 32'(key_out), 32'(GOOD));
    check("t4_locked_valid", 32'(key_valid), 1);
    check("t4_locked_sready", 32'(key_sready), 0);

    // Bad parity then good load
    do_reset();
    e0 = err_seen;
    load_key(GOOD, 1'b0, 0, 1'b0);
    check("t2_err_pulse", 32'(load_err), 1);
    check("t2_key_def", 32'(key_out), 32'(DEF));
    check("t2_valid", 32'(key_valid), 0);
    check("t2_busy", 32'(busy), 0);
    check("t2_fail_cnt", 32'(dut.fail_cnt_q), 1);
    tick();
    check("t2_err_cleared", 32'(load_err), 0);
    check("t2_one_pulse", 32'(err_seen - e0), 1);
    load_key(GOOD, 1'b1, 0, 1'b0);
    tick();
    check("t2_relock_key", 32'(key_out), 32'(GOOD));
    check("t2_relock_valid", 32'(key_valid), 1);

    // Retry limit
    do_reset();
    load_key(GOOD, 1'b0, 0, 1'b0);
    tick();
    load_key(GOOD, 1'b0, 0, 1'b0);
    check("t3_no_fault_2", 32'(fault), 0);
    tick();
    load_key(GOOD, 1'b0, 0, 1'b0);
    check("t3_fault", 32'(fault), 1);
    check("t3_err3", 32'(load_err), 1);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    check("t3_no_sready", 32'(key_sready), 0);
    check("t3_fault_sticky", 32'(fault), 1);
    check("t3_fault_key", 32'(key_out), 32'(DEF));
    check("t3_fault_valid", 32'(key_valid), 0);
    do_reset();
    check("t3_reset_clears", 32'(fault), 0);

    // Stalls plus load_req pulse while busy
    load_key(GOOD, 1'b1, 5, 1'b1);
    tick();
    check("t4_stall_key", 32'(key_out), 32'(GOOD));
    check("t4_stall_valid", 32'(key_valid), 1);

    // Async reset mid-load
    do_reset();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    key_svalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_sdata = GOOD[i];
      tick();
    end
    key_svalid = 1'b0;
    check("t5_busy_before", 32'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy_async", 32'(busy), 0);
    check("t5_sready_async", 32'(key_sready), 0);
    check("t5_key_async", 32'(key_out), 32'(DEF));
    check("t5_bitcnt_async", 32'(dut.bit_cnt_q), 0);
    tick();
    rst_n = 1'b1;
    tick();
    load_key(GOOD, 1'b1, 0, 1'b0);
    tick();
    check("t5_reload_key", 32'(key_out), 32'(GOOD));
    check("t5_reload_valid", 32'(key_valid), 1);

    // Starved link
    do_reset();
    e0 = err_seen;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    key_svalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      key_sdata = GOOD[i];
      tick();
    end
    key_svalid = 1'b0;
`ifdef KEY_LOAD_TIMEOUT_EN
    n = 0;
    hit = 1'b0;
    while (n < 40 && !hit) begin
      tick();
      n++;
      if (load_err === 1'b1) hit = 1'b1;
    end
    check("t6_timeout_seen", 32'(hit), 1);
    check("t6_timeout_cycles", 32'(n), 16);
    check("t6_idle", 32'(busy), 0);
    check("t6_fail_cnt", 32'(dut.fail_cnt_q), 1);
    tick();
    check("t6_err_cleared", 32'(load_err), 0);
`else
    n = 0;
    hit = 1'b0;
    repeat (1000) tick();
    check("t6_still_busy", 32'(busy), 1);
    check("t6_still_sready", 32'(key_sready), 1);
    check("t6_no_err", 32'(err_seen - e0), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
